// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for the UART receiver: serial line, pop handshake and status flags.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             uart_rx;
  logic             rd_en;
  logic             clr_err;
  logic [7:0]       rd_data;
  logic             rx_empty;
  logic             rx_full;
  logic [CNT_W-1:0] rx_count;
  logic             overrun;
  logic             frame_err;

  modport master (
    output uart_rx, rd_en, clr_err,
    input  rd_data, rx_empty, rx_full, rx_count, overrun, frame_err
  );

  modport slave (
    input  uart_rx, rd_en, clr_err,
    output rd_data, rx_empty, rx_full, rx_count, overrun, frame_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CLK_W-1:0] HALF = CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CLK_W-1:0] LAST = CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic             sync1_q, sync2_q, prev_q;
  logic             rx_s, fall;
  state_t           state_q, state_d;
  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             ferr_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, frame_err_q;
  logic             empty, full, do_push, do_pop, ovr_set;

  // Input synchroniser and falling-edge detector; idle line level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s = sync2_q;
  assign fall = prev_q & ~rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      push_q    <= push_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint was only a glitch
        if (clk_cnt_q == HALF) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO: occupancy counter distinguishes full from empty with equal pointers
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = bus.rd_en & ~empty;
  assign do_push = push_q & (~full | bus.rd_en);
  assign ovr_set = push_q & full & ~bus.rd_en;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
      overrun_q   <= ovr_set  ? 1'b1 : (bus.clr_err ? 1'b0 : overrun_q);
      frame_err_q <= ferr_set ? 1'b1 : (bus.clr_err ? 1'b0 : frame_err_q);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign bus.rd_data   = empty ? 8'h00 : mem[rd_ptr_q];
  assign bus.rx_empty  = empty;
  assign bus.rx_full   = full;
  assign bus.rx_count  = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
endmodule
